// File: rtl/wb_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_unit_pkg
// Brief    : Shared widths, register constants and source encoding for the
//            writeback unit.
// Revision : 1.0
// ============================================================================
package wb_unit_pkg;

  localparam int WB_XLEN       = 32;
  localparam int WB_REG_NUM    = 32;
  localparam int REG_IDX_WIDTH = 5;
  localparam int REG_X0        = 0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_MDU  = 2'd3
  } src_e;

  // Round-robin hand-off between the two handshaked sources.
  function automatic src_e rr_next(input src_e granted, input src_e cur);
    src_e nxt;
    nxt = cur;
    if (granted == SRC_LSU) nxt = SRC_MDU;
    if (granted == SRC_MDU) nxt = SRC_LSU;
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : wb_scoreboard
// Brief    : Pending-write mask for long-latency destinations; x0 never pends.
// Revision : 1.0
// ============================================================================
module wb_scoreboard
  import wb_unit_pkg::*;
#(
  parameter int REG_NUM = WB_REG_NUM,
  parameter int IDX_W   = REG_IDX_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en,
  input  logic [IDX_W-1:0]   set_idx,
  input  logic               clr_en,
  input  logic [IDX_W-1:0]   clr_idx,
  output logic [REG_NUM-1:0] busy
);

  logic [REG_NUM-1:0] pending_q;
  logic [REG_NUM-1:0] pending_d;

  // Set is evaluated last so a new producer outlives a same-cycle retire.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < REG_NUM; i++) begin
      if (clr_en && (clr_idx == IDX_W'(i))) pending_d[i] = 1'b0;
      if (set_en && (set_idx == IDX_W'(i))) pending_d[i] = 1'b1;
    end
    pending_d[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign busy = pending_q;

endmodule
`default_nettype wire

// File: rtl/wb_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_unit
// Brief    : Writeback arbiter (ALU > round-robin LSU/MDU), registered regfile
//            write port and pending-write scoreboard.
// Revision : 1.0
// ============================================================================
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int XLEN    = WB_XLEN,
  parameter int REG_NUM = WB_REG_NUM,
  parameter int IDX_W   = REG_IDX_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_vld_i,
  input  logic [IDX_W-1:0]   alu_idx_i,
  input  logic [XLEN-1:0]    alu_data_i,
  input  logic               lsu_vld_i,
  output logic               lsu_rdy_o,
  input  logic [IDX_W-1:0]   lsu_idx_i,
  input  logic [XLEN-1:0]    lsu_data_i,
  input  logic               mdu_vld_i,
  output logic               mdu_rdy_o,
  input  logic [IDX_W-1:0]   mdu_idx_i,
  input  logic [XLEN-1:0]    mdu_data_i,
  input  logic               iss_en_i,
  input  logic [IDX_W-1:0]   iss_idx_i,
  output logic               rd_en_o,
  output logic [IDX_W-1:0]   rd_idx_o,
  output logic [XLEN-1:0]    rd_wdata_o,
  output logic [REG_NUM-1:0] busy_o
);

  src_e             win;
  src_e             rr_q;
  src_e             rr_d;
  logic [IDX_W-1:0] win_idx;
  logic [XLEN-1:0]  win_data;
  logic             lsu_rdy;
  logic             mdu_rdy;

  logic             rd_en_q;
  logic             rd_en_d;
  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] rd_idx_d;
  logic [XLEN-1:0]  rd_wdata_q;
  logic [XLEN-1:0]  rd_wdata_d;

  // ALU is unconditional; the pointer only breaks LSU/MDU ties.
  always_comb begin
    win     = SRC_NONE;
    lsu_rdy = 1'b0;
    mdu_rdy = 1'b0;
    if (alu_vld_i) begin
      win = SRC_ALU;
    end else if (lsu_vld_i && mdu_vld_i) begin
      win     = rr_q;
      lsu_rdy = (rr_q == SRC_LSU);
      mdu_rdy = (rr_q == SRC_MDU);
    end else if (lsu_vld_i) begin
      win     = SRC_LSU;
      lsu_rdy = 1'b1;
    end else if (mdu_vld_i) begin
      win     = SRC_MDU;
      mdu_rdy = 1'b1;
    end
  end

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    case (win)
      SRC_ALU: begin
        win_idx  = alu_idx_i;
        win_data = alu_data_i;
      end
      SRC_LSU: begin
        win_idx  = lsu_idx_i;
        win_data = lsu_data_i;
      end
      SRC_MDU: begin
        win_idx  = mdu_idx_i;
        win_data = mdu_data_i;
      end
      default: begin
        win_idx  = '0;
        win_data = '0;
      end
    endcase
  end

  // Index/data hold on idle cycles so the forwarding path stays stable.
  always_comb begin
    rr_d       = rr_next(win, rr_q);
    rd_en_d    = 1'b0;
    rd_idx_d   = rd_idx_q;
    rd_wdata_d = rd_wdata_q;
    if (win != SRC_NONE) begin
      rd_en_d    = (win_idx != IDX_W'(REG_X0));
      rd_idx_d   = win_idx;
      rd_wdata_d = win_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= SRC_LSU;
      rd_en_q    <= 1'b0;
      rd_idx_q   <= '0;
      rd_wdata_q <= '0;
    end else begin
      rr_q       <= rr_d;
      rd_en_q    <= rd_en_d;
      rd_idx_q   <= rd_idx_d;
      rd_wdata_q <= rd_wdata_d;
    end
  end

  wb_scoreboard #(
    .REG_NUM (REG_NUM),
    .IDX_W   (IDX_W)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (iss_en_i),
    .set_idx (iss_idx_i),
    .clr_en  (lsu_rdy || mdu_rdy),
    .clr_idx (win_idx),
    .busy    (busy_o)
  );

  assign lsu_rdy_o  = lsu_rdy;
  assign mdu_rdy_o  = mdu_rdy;
  assign rd_en_o    = rd_en_q;
  assign rd_idx_o   = rd_idx_q;
  assign rd_wdata_o = rd_wdata_q;

endmodule
`default_nettype wire

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Writeback unit that drives the regfile write port (rd_en/rd_idx/rd_wdata).
- Merges three result sources:
  - ALU: single-cycle, no backpressure.
  - LSU: load data, valid/ready.
  - MDU: mul/div, valid/ready.
- Maintains a pending-write scoreboard for long-latency destinations, so decode can stall on RAW hazards.
- Sits between execute/LSU/MDU and the regfile; the registered write is also the forwarding source for decode.

Parameters:
- XLEN, 32, data width.
- REG_NUM, 32, number of architectural registers (x0 included).
- IDX_W, 5, register index width; clog2(REG_NUM).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- alu_vld_i  input  1  ALU result valid; always accepted
- alu_idx_i  input  IDX_W  ALU destination
- alu_data_i  input  XLEN  ALU result
- lsu_vld_i  input  1  LSU result valid
- lsu_rdy_o  output  1  LSU result accepted this cycle
- lsu_idx_i  input  IDX_W  LSU destination
- lsu_data_i  input  XLEN  LSU result
- mdu_vld_i  input  1  MDU result valid
- mdu_rdy_o  output  1  MDU result accepted this cycle
- mdu_idx_i  input  IDX_W  MDU destination
- mdu_data_i  input  XLEN  MDU result
- iss_en_i  input  1  decode issues a long-latency op (LSU load / MDU)
- iss_idx_i  input  IDX_W  destination of issued op
- rd_en_o  output  1  regfile write enable
- rd_idx_o  output  IDX_W  regfile write index
- rd_wdata_o  output  XLEN  regfile write data
- busy_o  output  REG_NUM  per-register pending-write mask; bit 0 always 0

Behaviour:
- Reset:
  - rd_en_o=0, rd_idx_o=0, rd_wdata_o=0.
  - Pending scoreboard all 0.
  - Round-robin pointer = LSU.
  - lsu_rdy_o/mdu_rdy_o follow the combinational rules below; with both valids low they are don't-care-but-defined. They are 0 when the corresponding valid is low.
- Arbitration (combinational, one winner per cycle):
  - Priority 1: ALU. If alu_vld_i, ALU wins and lsu_rdy_o=mdu_rdy_o=0.
  - Otherwise, if only one of LSU/MDU is valid, that one wins and its rdy=1.
  - Otherwise, if both are valid, the pointer owner wins.
  - The pointer flips to the other source after any LSU or MDU grant. It is unchanged on ALU grants and idle cycles.
- Handshake:
  - Transfer occurs when vld & rdy in the same cycle.
  - Sources hold vld/idx/data stable until accepted.
  - The block never asserts rdy without vld.
- Write register (1-cycle latency):
  - At the edge after a grant: rd_en_o=1 if winner idx != 0, else 0. rd_idx_o=winner idx; rd_wdata_o=winner data.
  - No grant: rd_en_o=0; rd_idx_o/rd_wdata_o hold their previous values.
  - A write to x0 completes the handshake but produces no write.
- Scoreboard:
  - pending[1..REG_NUM-1].
  - Set: iss_en_i & iss_idx_i!=0 sets pending[iss_idx_i] at the clock edge.
  - Clear: an accepted LSU or MDU transfer clears pending[idx] at the same edge. ALU transfers never touch the scoreboard.
  - Set and clear of the same idx in the same cycle: set wins (new producer outstanding).
  - Set of an already pending idx: stays 1. Decode must not issue to a pending idx; that is not checked here.
  - busy_o = registered pending vector; bit 0 hardwired 0.
- Simultaneous events:
  - ALU valid every cycle starves LSU/MDU. This is accepted; the pipeline guarantees ALU bubbles.
  - LSU and MDU both valid with no ALU: they alternate strictly.
- Reset mid-operation: all state clears immediately. In-flight results are lost; sources are reset by the same rst_n.

Decomposition:
- Shared defines header: XLEN, REG_IDX_WIDTH, REG_X0, source encoding constants (SRC_ALU/SRC_LSU/SRC_MDU).
- Sub-module wb_scoreboard:
  - Holds the pending vector with its set/clear logic.
  - Inputs: set_en/set_idx, clr_en/clr_idx. Output: busy.
- Arbiter and write register stay in wb_unit.

Test Plan:
1. Single sources:
   - ALU only: alu_vld_i=1, idx=5, data=0x1234 → next cycle rd_en_o=1, rd_idx_o=5, rd_wdata_o=0x1234.
   - lsu_rdy_o=0 throughout.
2. Contention:
   - ALU (idx 3, 0xA) and LSU (idx 7, 0xB) valid together → cycle 1: ALU written, lsu_rdy_o=0.
   - ALU drops → cycle 2: lsu_rdy_o=1. Next cycle: rd_idx_o=7, rd_wdata_o=0xB.
3. Round-robin:
   - After reset, LSU (idx 8) and MDU (idx 9) held valid, ALU idle → grants in order LSU, MDU.
   - Two new results on each → grants LSU, MDU, LSU, MDU.
   - No source is granted twice in a row.
4. Scoreboard:
   - Issue idx 10 → busy_o[10]=1 the next cycle.
   - MDU result idx 10 accepted → busy_o[10]=0 after that edge.
   - Issue idx 10 in the same cycle as the MDU idx 10 accept → busy_o[10] stays 1.
5. x0:
   - LSU valid with idx 0 → lsu_rdy_o=1, rd_en_o stays 0, busy_o[0]=0.
   - iss_en_i with idx 0 → busy_o unchanged.
6. Reset mid-stream:
   - Pending bits 4 and 6 set and LSU waiting; assert rst_n=0 asynchronously → busy_o=0 and rd_en_o=0 immediately.
   - After release, the pointer starts at LSU.
